dwc_pipe: RTL and testbench

Parametrised duplication-with-comparison (DwC) datapath stage. Two independent copies of a WIDTH-bit bitwise logic operation run side by side, each through its own DEPTH-stage register pipeline, with a valid bit alongside. The final-stage outputs are compared every valid cycle. The block reports an instantaneous error, a sticky error flag, a saturating error counter and a first-error bit mask. It replaces single-bit, single-stage DwC cells in the fault-tolerant case studies.

---
 rtl/dwc_pkg.sv | 22 ++
 rtl/dwc_pipe_if.sv | 27 ++
 rtl/dwc_compare.sv | 16 +
 rtl/dwc_lane.sv | 28 ++
 rtl/dwc_pipe.sv | 100 ++++++++++
 tb/tb_dwc_pipe.sv | 189 ++++++++++++++++++
 6 files changed

// File: rtl/dwc_pkg.sv
// Shared types and the bitwise operation evaluator used by both DwC copies.
package dwc_pkg;

   typedef enum logic [1:0] {
      OP_AND = 2'd0,
      OP_OR  = 2'd1,
      OP_XOR = 2'd2
   } op_e;

   // Single-bit evaluator; callers apply it per bit so each copy gets its own gates.
   function automatic logic dwc_op(op_e sel, logic a, logic b);
      logic res;
      case (sel)
         OP_AND:  res = a & b;
         OP_OR:   res = a | b;
         OP_XOR:  res = a ^ b;
         default: res = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/dwc_pipe_if.sv
// Operand/result/error bundle of the DwC stage.
interface dwc_pipe_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
);
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_valid;
   logic [WIDTH-1:0] inj_mask;
   logic             err_clear;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             err_now;
   logic             err_sticky;
   logic [CNT_W-1:0] err_count;
   logic [WIDTH-1:0] err_mask;

   modport master (
      output in_a, in_b, in_valid, inj_mask, err_clear,
      input  out_data, out_valid, err_now, err_sticky, err_count, err_mask
   );

   modport slave (
      input  in_a, in_b, in_valid, inj_mask, err_clear,
      output out_data, out_valid, err_now, err_sticky, err_count, err_mask
   );
endinterface

// File: rtl/dwc_compare.sv
// Final-stage comparator: err = 1 when the valid copies disagree.
module dwc_compare #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             valid,
   output logic [WIDTH-1:0] diff,
   output logic             err
);
   // Bitwise difference and the valid-qualified mismatch flag.
   always_comb begin
      diff = a ^ b;
      err  = valid & (|diff);
   end
endmodule

// File: rtl/dwc_lane.sv
// Generic DEPTH-deep register chain; loads every cycle, no enable.
module dwc_lane #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   logic [WIDTH-1:0] stage_r [DEPTH];

   // Shift the chain by one stage each clock; reset flushes every stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_r[i] <= '0;
         end
      end else begin
         stage_r[0] <= d;
         for (int i = 1; i < DEPTH; i++) begin
            stage_r[i] <= stage_r[i-1];
         end
      end
   end

   assign q = stage_r[DEPTH-1];
endmodule

// File: rtl/dwc_pipe.sv
// Duplication-with-comparison datapath stage: two independent copies of a
// bitwise operation, compared at the last pipeline stage, with error logging.
module dwc_pipe
   import dwc_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 1,
   parameter int CNT_W = 8,
   parameter int OP    = 0
) (
   input logic       clk,
   input logic       rst_n,
   dwc_pipe_if.slave bus
);
   if (OP < 0 || OP > 2) begin : g_bad_op
      $error("dwc_pipe: OP must be 0 (AND), 1 (OR) or 2 (XOR)");
   end

   localparam op_e OP_SEL = op_e'(OP);

   logic [WIDTH-1:0] res0_s;
   logic [WIDTH-1:0] res1_s;
   logic [WIDTH-1:0] fin0_s;
   logic [WIDTH-1:0] fin1_s;
   logic             valid_s;
   logic [WIDTH-1:0] diff_s;
   logic             err_s;
   logic             err_sticky_r;
   logic [CNT_W-1:0] err_count_r;
   logic [WIDTH-1:0] err_mask_r;

   // Stage-0 inputs of both copies, evaluated separately; copy 1 carries the injection.
   always_comb begin
      res0_s = '0;
      res1_s = '0;
      for (int i = 0; i < WIDTH; i++) begin
         res0_s[i] = dwc_op(OP_SEL, bus.in_a[i], bus.in_b[i]);
         res1_s[i] = dwc_op(OP_SEL, bus.in_a[i], bus.in_b[i]) ^ bus.inj_mask[i];
      end
   end

   (* dont_touch = "true" *)
   dwc_lane #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane0 (
      .clk(clk), .rst_n(rst_n), .d(res0_s), .q(fin0_s)
   );

   (* dont_touch = "true" *)
   dwc_lane #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane1 (
      .clk(clk), .rst_n(rst_n), .d(res1_s), .q(fin1_s)
   );

   dwc_lane #(.WIDTH(1), .DEPTH(DEPTH)) u_valid (
      .clk(clk), .rst_n(rst_n), .d(bus.in_valid), .q(valid_s)
   );

   dwc_compare #(.WIDTH(WIDTH)) u_cmp (
      .a(fin0_s), .b(fin1_s), .valid(valid_s), .diff(diff_s), .err(err_s)
   );

   // Error log: a mismatch beats a simultaneous clear and restarts the log from it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_sticky_r <= 1'b0;
         err_count_r  <= '0;
         err_mask_r   <= '0;
      end else if (err_s) begin
         err_sticky_r <= 1'b1;
         if (bus.err_clear) begin
            err_count_r <= CNT_W'(1);
            err_mask_r  <= diff_s;
         end else begin
            if (err_count_r != {CNT_W{1'b1}}) begin
               err_count_r <= err_count_r + CNT_W'(1);
            end else begin
               err_count_r <= err_count_r;
            end
            if (!err_sticky_r) begin
               err_mask_r <= diff_s;
            end else begin
               err_mask_r <= err_mask_r;
            end
         end
      end else if (bus.err_clear) begin
         err_sticky_r <= 1'b0;
         err_count_r  <= '0;
         err_mask_r   <= '0;
      end else begin
         err_sticky_r <= err_sticky_r;
         err_count_r  <= err_count_r;
         err_mask_r   <= err_mask_r;
      end
   end

   assign bus.out_data   = fin0_s;
   assign bus.out_valid  = valid_s;
   assign bus.err_now    = err_s;
   assign bus.err_sticky = err_sticky_r;
   assign bus.err_count  = err_count_r;
   assign bus.err_mask   = err_mask_r;
endmodule

// File: tb/tb_dwc_pipe.sv
// Directed bench for dwc_pipe: main instance (CNT_W = 8) plus a CNT_W = 2
// instance for counter saturation; both WIDTH = 8, DEPTH = 2, OP = AND.
module tb_dwc_pipe;
   logic clk;
   logic rst_n;
   int   checks;
   int   failures;
   logic [1:0] exp_sat [5];

   dwc_pipe_if #(.WIDTH(8), .CNT_W(8)) bus ();
   dwc_pipe_if #(.WIDTH(8), .CNT_W(2)) sbus ();

   dwc_pipe #(.WIDTH(8), .DEPTH(2), .CNT_W(8), .OP(0)) u_dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   dwc_pipe #(.WIDTH(8), .DEPTH(2), .CNT_W(2), .OP(0)) u_dut_sat (
      .clk(clk), .rst_n(rst_n), .bus(sbus)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic v, input logic [7:0] inj);
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_valid = v;
      bus.inj_mask = inj;
   endtask

   // Linear sequence of directed steps.
   initial begin
      checks   = 0;
      failures = 0;
      exp_sat[0] = 2'd1; exp_sat[1] = 2'd2; exp_sat[2] = 2'd3;
      exp_sat[3] = 2'd3; exp_sat[4] = 2'd3;
      rst_n = 1'b0;
      drive(8'h00, 8'h00, 1'b0, 8'h00);
      bus.err_clear  = 1'b0;
      sbus.in_a      = 8'h00;
      sbus.in_b      = 8'h00;
      sbus.in_valid  = 1'b0;
      sbus.inj_mask  = 8'h00;
      sbus.err_clear = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_out_data",   bus.out_data,          8'h00);
      chk("rst_out_valid",  8'(bus.out_valid),     8'h00);
      chk("rst_err_now",    8'(bus.err_now),       8'h00);
      chk("rst_err_sticky", 8'(bus.err_sticky),    8'h00);
      chk("rst_err_count",  bus.err_count,         8'h00);
      chk("rst_err_mask",   bus.err_mask,          8'h00);
      rst_n = 1'b1;
      tick();

      // Clean AND result, 2-cycle latency.
      drive(8'hF0, 8'h3C, 1'b1, 8'h00);
      tick();
      drive(8'h00, 8'h00, 1'b0, 8'h00);
      chk("lat1_out_valid", 8'(bus.out_valid), 8'h00);
      tick();
      chk("lat2_out_data",  bus.out_data,      8'h30);
      chk("lat2_out_valid", 8'(bus.out_valid), 8'h01);
      chk("lat2_err_now",   8'(bus.err_now),   8'h00);
      tick();
      chk("lat3_out_valid", 8'(bus.out_valid), 8'h00);
      chk("lat3_err_count", bus.err_count,     8'h00);

      // Single injection of 0x01.
      drive(8'hF0, 8'h3C, 1'b1, 8'h01);
      tick();
      drive(8'h00, 8'h00, 1'b0, 8'h00);
      tick();
      chk("inj1_err_now",  8'(bus.err_now), 8'h01);
      chk("inj1_out_data", bus.out_data,    8'h30);
      tick();
      chk("inj1_err_now_gone", 8'(bus.err_now),    8'h00);
      chk("inj1_sticky",       8'(bus.err_sticky), 8'h01);
      chk("inj1_count",        bus.err_count,      8'h01);
      chk("inj1_mask",         bus.err_mask,       8'h01);

      // Clear, then two injections three cycles apart.
      bus.err_clear = 1'b1;
      tick();
      bus.err_clear = 1'b0;
      chk("clr_sticky", 8'(bus.err_sticky), 8'h00);
      chk("clr_count",  bus.err_count,      8'h00);
      chk("clr_mask",   bus.err_mask,       8'h00);
      drive(8'hF0, 8'h3C, 1'b1, 8'h01);
      tick();
      drive(8'h00, 8'h00, 1'b0, 8'h00);
      tick();
      tick();
      drive(8'hF0, 8'h3C, 1'b1, 8'h80);
      tick();
      drive(8'h00, 8'h00, 1'b0, 8'h00);
      tick();
      chk("inj2_err_now", 8'(bus.err_now), 8'h01);
      tick();
      chk("inj2_count",  bus.err_count,      8'h02);
      chk("inj2_mask",   bus.err_mask,       8'h01);
      chk("inj2_sticky", 8'(bus.err_sticky), 8'h01);

      // Clear coinciding with an error (diff 0x04): the error wins.
      drive(8'hF0, 8'h3C, 1'b1, 8'h04);
      tick();
      drive(8'h00, 8'h00, 1'b0, 8'h00);
      tick();
      chk("clrerr_err_now", 8'(bus.err_now), 8'h01);
      bus.err_clear = 1'b1;
      tick();
      bus.err_clear = 1'b0;
      chk("clrerr_sticky", 8'(bus.err_sticky), 8'h01);
      chk("clrerr_count",  bus.err_count,      8'h01);
      chk("clrerr_mask",   bus.err_mask,       8'h04);

      // Saturating counter (CNT_W = 2): five consecutive injected words.
      sbus.in_a     = 8'hF0;
      sbus.in_b     = 8'h3C;
      sbus.in_valid = 1'b1;
      sbus.inj_mask = 8'h01;
      for (int j = 1; j <= 7; j++) begin
         tick();
         if (j == 5) begin
            sbus.in_valid = 1'b0;
            sbus.inj_mask = 8'h00;
         end
         if (j >= 3) begin
            chk($sformatf("sat_count_%0d", j - 2), 8'(sbus.err_count), 8'(exp_sat[j-3]));
         end
      end

      // Injection without valid is not reported.
      bus.err_clear = 1'b1;
      tick();
      bus.err_clear = 1'b0;
      drive(8'hF0, 8'h3C, 1'b0, 8'hFF);
      tick();
      drive(8'h00, 8'h00, 1'b0, 8'h00);
      tick();
      chk("novalid_err_now", 8'(bus.err_now), 8'h00);
      tick();
      chk("novalid_sticky", 8'(bus.err_sticky), 8'h00);
      chk("novalid_count",  bus.err_count,      8'h00);

      // Asynchronous reset with injected words in flight.
      drive(8'hF0, 8'h3C, 1'b1, 8'h01);
      tick();
      drive(8'hF0, 8'h3C, 1'b1, 8'h02);
      tick();
      chk("flush_pre_err_now",  8'(bus.err_now), 8'h01);
      chk("flush_pre_out_data", bus.out_data,    8'h30);
      #1;
      rst_n = 1'b0;
      drive(8'h00, 8'h00, 1'b0, 8'h00);
      #1;
      chk("flush_out_data",  bus.out_data,       8'h00);
      chk("flush_out_valid", 8'(bus.out_valid),  8'h00);
      chk("flush_err_now",   8'(bus.err_now),    8'h00);
      chk("flush_sticky",    8'(bus.err_sticky), 8'h00);
      chk("flush_count",     bus.err_count,      8'h00);
      chk("flush_mask",      bus.err_mask,       8'h00);
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      chk("post_out_valid", 8'(bus.out_valid),  8'h00);
      chk("post_err_now",   8'(bus.err_now),    8'h00);
      tick();
      chk("post_sticky",    8'(bus.err_sticky), 8'h00);
      chk("post_count",     bus.err_count,      8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
